// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, one-hot instruction type and field payload.
package rv32i_pkg;

  localparam int unsigned TYPE_W = 9;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_LW    = 7'h03;
  localparam logic [6:0] OP_ADDI  = 7'h13;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_S     = 7'h23;
  localparam logic [6:0] OP_SB    = 7'h63;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_UJ    = 7'h6F;

  localparam int unsigned T_R     = 0;
  localparam int unsigned T_LW    = 1;
  localparam int unsigned T_ADDI  = 2;
  localparam int unsigned T_JALR  = 3;
  localparam int unsigned T_S     = 4;
  localparam int unsigned T_SB    = 5;
  localparam int unsigned T_AUIPC = 6;
  localparam int unsigned T_LUI   = 7;
  localparam int unsigned T_UJ    = 8;

  typedef logic [TYPE_W-1:0] instr_type_t;

  typedef struct packed {
    instr_type_t itype;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        illegal;
  } dec_fields_t;

  // Opcode to one-hot type; unknown opcodes yield all-zero.
  function automatic instr_type_t decode_type(input logic [6:0] op);
    instr_type_t t;
    t = '0;
    case (op)
      OP_R:     t[T_R]     = 1'b1;
      OP_LW:    t[T_LW]    = 1'b1;
      OP_ADDI:  t[T_ADDI]  = 1'b1;
      OP_JALR:  t[T_JALR]  = 1'b1;
      OP_S:     t[T_S]     = 1'b1;
      OP_SB:    t[T_SB]    = 1'b1;
      OP_AUIPC: t[T_AUIPC] = 1'b1;
      OP_LUI:   t[T_LUI]   = 1'b1;
      OP_UJ:    t[T_UJ]    = 1'b1;
      default:  t          = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: selects the RV32I immediate format from the one-hot type
// and sign-extends it from instr[31] to XLEN.
module imm_gen
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  instr_type_t     type_i,
  output logic [XLEN-1:0] imm_o
);

  logic        sgn;
  logic signed [31:0] raw;

  assign sgn = instr_i[31];

  always_comb begin
    raw = '0;
    if (type_i[T_LW] || type_i[T_ADDI] || type_i[T_JALR]) begin
      raw = {{20{sgn}}, instr_i[31:20]};
    end else if (type_i[T_S]) begin
      raw = {{20{sgn}}, instr_i[31:25], instr_i[11:7]};
    end else if (type_i[T_SB]) begin
      raw = {{19{sgn}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    end else if (type_i[T_LUI] || type_i[T_AUIPC]) begin
      raw = {instr_i[31:12], 12'b0};
    end else if (type_i[T_UJ]) begin
      raw = {{11{sgn}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    end
  end

  // Signed size cast replicates bit 31 when XLEN is 64.
  assign imm_o = XLEN'(raw);

endmodule

// File: rtl/id_decode_reg.sv
// Instruction decode stage: combinational RV32I decode into a one-entry
// valid/ready output register, plus a saturating illegal-opcode counter.
module id_decode_reg
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8:0]       out_type,
  output logic [XLEN-1:0]  out_imm,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  instr_type_t      type_c;
  logic [XLEN-1:0]  imm_c;
  dec_fields_t      fields_c;
  logic             accept_c;

  logic             valid_q, valid_d;
  dec_fields_t      fields_q, fields_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign type_c = decode_type(instr[6:0]);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (instr),
    .type_i  (type_c),
    .imm_o   (imm_c)
  );

  always_comb begin
    fields_c.itype   = type_c;
    fields_c.rd      = instr[11:7];
    fields_c.rs1     = instr[19:15];
    fields_c.rs2     = instr[24:20];
    fields_c.funct3  = instr[14:12];
    fields_c.funct7  = instr[31:25];
    fields_c.illegal = (type_c == '0);
  end

  assign in_ready = !valid_q || out_ready;
  assign accept_c = in_valid && in_ready && !flush;

  // Flush wins over both a new transfer and a plain drain.
  always_comb begin
    valid_d  = valid_q;
    fields_d = fields_q;
    imm_d    = imm_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_c) begin
      valid_d  = 1'b1;
      fields_d = fields_c;
      imm_d    = imm_c;
      pc_d     = pc_in;
      if (fields_c.illegal && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      fields_q <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      fields_q <= fields_d;
      imm_q    <= imm_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_type      = fields_q.itype;
  assign out_imm       = imm_q;
  assign out_rd        = fields_q.rd;
  assign out_rs1       = fields_q.rs1;
  assign out_rs2       = fields_q.rs2;
  assign out_funct3    = fields_q.funct3;
  assign out_funct7    = fields_q.funct7;
  assign out_pc        = pc_q;
  assign out_illegal   = fields_q.illegal;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_id_decode_reg.sv
// Bench for id_decode_reg: a 32-bit/16-bit-counter and a 64-bit/2-bit-counter
// instance share stimulus and are checked against a transaction-level model.
module tb_id_decode_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [63:0] pc_drv = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        rdy32, val32, ill32;
  logic [8:0]  typ32;
  logic [31:0] imm32, pc32;
  logic [4:0]  rd32, rs1_32, rs2_32;
  logic [2:0]  f3_32;
  logic [6:0]  f7_32;
  logic [15:0] cnt32;

  logic        rdy64, val64, ill64;
  logic [8:0]  typ64;
  logic [63:0] imm64, pc64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  f3_64;
  logic [6:0]  f7_64;
  logic [1:0]  cnt64;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: one held instruction and an unsaturated illegal tally.
  bit          m_valid = 1'b0;
  bit [31:0]   m_instr = '0;
  bit [63:0]   m_pc = '0;
  int          m_ill = 0;

  always #5 clk = ~clk;

  id_decode_reg dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .instr(instr),
    .pc_in(pc_drv[31:0]), .flush(flush), .out_valid(val32), .out_ready(out_ready),
    .out_type(typ32), .out_imm(imm32), .out_rd(rd32), .out_rs1(rs1_32), .out_rs2(rs2_32),
    .out_funct3(f3_32), .out_funct7(f7_32), .out_pc(pc32), .out_illegal(ill32),
    .illegal_count(cnt32)
  );

  id_decode_reg #(.XLEN(64), .CNT_W(2)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .instr(instr),
    .pc_in(pc_drv), .flush(flush), .out_valid(val64), .out_ready(out_ready),
    .out_type(typ64), .out_imm(imm64), .out_rd(rd64), .out_rs1(rs1_64), .out_rs2(rs2_64),
    .out_funct3(f3_64), .out_funct7(f7_64), .out_pc(pc64), .out_illegal(ill64),
    .illegal_count(cnt64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ref_type(input bit [31:0] w);
    case (w[6:0])
      7'h33: return 9'h001;
      7'h03: return 9'h002;
      7'h13: return 9'h004;
      7'h67: return 9'h008;
      7'h23: return 9'h010;
      7'h63: return 9'h020;
      7'h17: return 9'h040;
      7'h37: return 9'h080;
      7'h6F: return 9'h100;
      default: return 9'h000;
    endcase
  endfunction

  // Immediate as a signed integer, assembled arithmetically from the fields.
  function automatic longint ref_imm(input bit [31:0] w);
    longint v;
    v = 0;
    case (w[6:0])
      7'h03, 7'h13, 7'h67: begin
        v = longint'(w[31:20]);
        if (v >= 2048) v -= 4096;
      end
      7'h23: begin
        v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'h63: begin
        v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048
          + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      7'h17, 7'h37: begin
        v = longint'(w[31:12]) * 4096;
        if (w[31]) v -= 64'sd4294967296;
      end
      7'h6F: begin
        v = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096
          + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  task automatic check_outputs();
    longint    e_imm;
    bit [63:0] e_imm_u;
    bit [8:0]  e_typ;
    check("valid32", 64'(val32), 64'(m_valid));
    check("valid64", 64'(val64), 64'(m_valid));
    check("cnt32", 64'(cnt32), 64'((m_ill > 65535) ? 65535 : m_ill));
    check("cnt64", 64'(cnt64), 64'((m_ill > 3) ? 3 : m_ill));
    if (m_valid) begin
      e_imm   = ref_imm(m_instr);
      e_imm_u = 64'(e_imm);
      e_typ   = ref_type(m_instr);
      check("type32", 64'(typ32), 64'(e_typ));
      check("type64", 64'(typ64), 64'(e_typ));
      check("imm32", 64'(imm32), {32'b0, e_imm_u[31:0]});
      check("imm64", imm64, e_imm_u);
      check("illegal32", 64'(ill32), 64'(e_typ == 9'h000));
      check("illegal64", 64'(ill64), 64'(e_typ == 9'h000));
      check("fields32", {29'b0, rd32, rs1_32, rs2_32, f3_32, f7_32},
            {29'b0, m_instr[11:7], m_instr[19:15], m_instr[24:20], m_instr[14:12], m_instr[31:25]});
      check("fields64", {29'b0, rd64, rs1_64, rs2_64, f3_64, f7_64},
            {29'b0, m_instr[11:7], m_instr[19:15], m_instr[24:20], m_instr[14:12], m_instr[31:25]});
      check("pc32", 64'(pc32), {32'b0, m_pc[31:0]});
      check("pc64", pc64, m_pc);
    end
  endtask

  // One clock of stimulus: drive, check in_ready, advance model, check outputs.
  task automatic step(input bit v, input bit [31:0] w, input bit [63:0] pc,
                      input bit ordy, input bit fl);
    bit e_rdy;
    in_valid  = v;
    instr     = w;
    pc_drv    = pc;
    out_ready = ordy;
    flush     = fl;
    #1;
    e_rdy = !m_valid || ordy;
    check("in_ready32", 64'(rdy32), 64'(e_rdy));
    check("in_ready64", 64'(rdy64), 64'(e_rdy));
    @(posedge clk);
    if (fl) begin
      m_valid = 1'b0;
    end else if (v && e_rdy) begin
      m_valid = 1'b1;
      m_instr = w;
      m_pc    = pc;
      if (ref_type(w) == 9'h000) m_ill++;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
    check_outputs();
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    #1;
    m_valid = 1'b0;
    m_ill   = 0;
    check({tag, "_valid"}, 64'({val32, val64}), 64'(0));
    check({tag, "_cnt"}, 64'({cnt32, cnt64}), 64'(0));
    check({tag, "_ready"}, 64'({rdy32, rdy64}), 64'(2'b11));
    check({tag, "_type_imm"}, 64'({typ32, typ64, ill32, ill64}) | imm64 | 64'(imm32), 64'(0));
    check({tag, "_pc_fields"}, pc64 | 64'(pc32) | 64'({rd64, rs1_64, rs2_64, f3_64, f7_64}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit [6:0]  ops [10];
    bit [31:0] w;
    bit [63:0] pc;
    ops = '{7'h33, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h17, 7'h37, 7'h6F, 7'h7F};

    #1;
    apply_reset("rst0");

    // addi x1,x0,5
    step(1, 32'h0050_0093, 64'h100, 1, 0);
    check("addi_type", 64'(typ32), 64'h004);
    check("addi_imm", 64'(imm32), 64'd5);
    check("addi_rd", 64'(rd32), 64'd1);
    check("addi_pc", 64'(pc32), 64'h100);

    // beq with B-immediate -8
    step(1, 32'hFE01_0CE3, 64'h200, 1, 0);
    check("beq_type", 64'(typ64), 64'h020);
    check("beq_imm32", 64'(imm32), 64'hFFFF_FFF8);
    check("beq_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFF8);

    // Backpressure: B waits three cycles, accepted when out_ready returns
    step(1, 32'h0070_0113, 64'h300, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h00A0_0193, 64'h304, 0, 0);
      check("stall_ready", 64'(rdy32), 64'd0);
      check("stall_rd", 64'(rd32), 64'd2);
    end
    step(1, 32'h00A0_0193, 64'h304, 1, 0);
    check("resume_rd", 64'(rd32), 64'd3);
    check("resume_pc", 64'(pc32), 64'h304);
    step(0, 32'h0, 64'h0, 1, 0);
    check("drain_valid", 64'(val32), 64'd0);

    // Illegal opcode saturation on the 2-bit counter
    apply_reset("rst1");
    for (int i = 0; i < 4; i++) begin
      step(1, 32'hFFFF_FFFF, 64'h400, 1, 0);
      check("ill_flag", 64'(ill64), 64'd1);
      check("ill_type", 64'(typ64), 64'd0);
      check("ill_imm", imm64, 64'd0);
      check("ill_count", 64'(cnt64), 64'((i < 3) ? i + 1 : 3));
    end

    // Flush with a held bundle and an incoming illegal instruction
    apply_reset("rst2");
    step(1, 32'h0050_0093, 64'h500, 0, 0);
    step(1, 32'h0000_007F, 64'h504, 0, 1);
    check("flush_valid", 64'(val32), 64'd0);
    check("flush_cnt", 64'(cnt32), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      w = $urandom();
      w[6:0] = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 15) == 0) w[6:0] = 7'($urandom());
      pc = {$urandom(), $urandom()};
      step(bit'($urandom_range(0, 3) != 0), w, pc, bit'($urandom_range(0, 2) != 0),
           bit'($urandom_range(0, 19) == 0));
    end

    // Mid-stream reset while a bundle is held
    step(1, 32'h0000_007F, 64'h600, 0, 0);
    check("pre_rst_valid", 64'(val32), 64'd1);
    apply_reset("rst3");
    step(1, 32'h0050_0093, 64'h700, 1, 0);
    check("post_rst_accept", 64'(val32), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
